// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives pipeline-register
// write enables and bubble/flush controls for redirects, load-use hazards
// and multi-cycle mult/div occupancy of EX, plus saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memr,
  input  logic             ex_redirect,
  input  logic             ex_md_start,
  output logic             pc_wr,
  output logic             if_id_wr,
  output logic             id_ex_wr,
  output logic             ex_mem_wr,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MDWAIT} state_t;

  // Freeze cycle 0 happens in RUN, so MDWAIT counts down from MD_CYCLES-2.
  localparam logic [7:0] MD_INIT = 8'(MD_CYCLES - 2);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             stall_inc;
  logic             flush_inc;

  assign load_use = ex_memr && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_use_rt && (ex_rt == id_rt)));

  // Next-state, counter increments and combinational pipeline controls.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    pc_wr         = 1'b1;
    if_id_wr      = 1'b1;
    id_ex_wr      = 1'b1;
    ex_mem_wr     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    md_done       = 1'b0;
    md_busy       = (state_q == MDWAIT);
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_inc    = 1'b1;
        end else if (ex_md_start) begin
          pc_wr         = 1'b0;
          if_id_wr      = 1'b0;
          id_ex_wr      = 1'b0;
          ex_mem_bubble = 1'b1;
          stall_inc     = 1'b1;
          state_d       = MDWAIT;
          cnt_d         = MD_INIT;
        end else if (load_use) begin
          pc_wr        = 1'b0;
          if_id_wr     = 1'b0;
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
        end
      end
      MDWAIT: begin
        if (cnt_q != 8'd0) begin
          pc_wr         = 1'b0;
          if_id_wr      = 1'b0;
          id_ex_wr      = 1'b0;
          ex_mem_bubble = 1'b1;
          stall_inc     = 1'b1;
          cnt_d         = cnt_q - 8'd1;
        end else begin
          md_done = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      pc_wr         = 1'b0;
      if_id_wr      = 1'b0;
      id_ex_wr      = 1'b0;
      ex_mem_wr     = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      md_busy       = 1'b0;
      md_done       = 1'b0;
    end
  end

  // Saturating performance counter next values.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State, countdown and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Drives the write enables of PC and of the IF/ID, ID/EX and EX/MEM pipeline registers, plus their flush/bubble controls.
- Resolves three hazard classes: taken branch/jump redirect from EX, load-use stall, and multi-cycle multiply/divide occupancy of EX.
- Keeps saturating performance counters for stall and flush cycles.
- Forwarding-mux selection stays in the bypass unit and is out of scope.

Parameters:
MD_CYCLES, 4, total cycles a mult/div instruction occupies EX; legal range is 2..255.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of the instruction in IF/ID
id_rt  in  5  rt field of the instruction in IF/ID
id_use_rt  in  1  the ID instruction reads rt as a source
ex_rt  in  5  rt (load destination) of the instruction in ID/EX
ex_memr  in  1  the ID/EX instruction is a load
ex_redirect  in  1  taken branch or jump resolved in EX this cycle
ex_md_start  in  1  the ID/EX instruction is mult/div; stays high while it sits in EX
pc_wr  out  1  PC write enable
if_id_wr  out  1  IF/ID write enable
id_ex_wr  out  1  ID/EX write enable
ex_mem_wr  out  1  EX/MEM write enable
if_id_flush  out  1  load NOP into IF/ID
id_ex_bubble  out  1  load zeroed control fields into ID/EX
ex_mem_bubble  out  1  load zeroed control fields into EX/MEM
md_busy  out  1  controller is in state MDWAIT
md_done  out  1  last EX cycle of a mult/div; the result is valid on the ALU output
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of redirect cycles

Behaviour:
- Reset is asynchronous:
  - state returns to RUN; cnt (8-bit), stall_cnt and flush_cnt return to 0.
  - While rst is high, every output is 0, including all write enables.
- The state machine has two states, RUN and MDWAIT. Outputs are combinational from state, cnt and inputs. Default output set: all *_wr=1, all flush/bubble=0, md_done=0.
- In RUN, the following priority applies (highest first):
  1. ex_redirect=1: default enables, plus if_id_flush=1 and id_ex_bubble=1. flush_cnt increments. ex_md_start is ignored; the two cannot both be high legitimately.
  2. ex_md_start=1 (freeze cycle 0):
     - pc_wr, if_id_wr and id_ex_wr are 0.
     - ex_mem_wr=1 with ex_mem_bubble=1.
     - Next state is MDWAIT, with cnt <= MD_CYCLES-2.
     - stall_cnt increments.
  3. Load-use, i.e. ex_memr=1, ex_rt!=0, and (ex_rt==id_rs or (id_use_rt and ex_rt==id_rt)):
     - pc_wr=0 and if_id_wr=0.
     - id_ex_wr=1 with id_ex_bubble=1.
     - stall_cnt increments.
     - This is a one-cycle stall; no state change.
  4. Otherwise: default outputs.
- In MDWAIT (md_busy=1):
  - cnt!=0:
    - Freeze exactly as in RUN priority 2 (pc_wr, if_id_wr, id_ex_wr = 0; ex_mem_bubble=1).
    - cnt decrements; stall_cnt increments.
    - ex_redirect and load-use are ignored.
  - cnt==0:
    - md_done=1 with default enables, so the mult/div advances to MEM.
    - Next state is RUN.
    - Load-use and redirect are not evaluated in this cycle.
- Net result: a mult/div causes exactly MD_CYCLES-1 freeze cycles and then one advance cycle.
- A new ex_md_start seen in RUN on the cycle after md_done starts a new sequence, since a new instruction is now in EX.
- Counters:
  - Each increments by 1 per qualifying cycle.
  - Each saturates at 2^CNT_W-1 and never wraps.
  - Both are cleared only by rst.
- A reset asserted mid-MDWAIT aborts the sequence immediately. After rst falls, state is RUN and cnt is 0.

Test Plan:
1. Reset: hold rst=1 with random inputs for 3 cycles -> all outputs 0; after release with idle inputs -> pc_wr=if_id_wr=id_ex_wr=ex_mem_wr=1, counters 0.
2. Load-use: ex_memr=1, ex_rt=5, id_rs=5, one cycle -> pc_wr=0, if_id_wr=0, id_ex_bubble=1, stall_cnt=1.
   - Repeat with ex_rt=0 -> no stall.
   - Repeat with id_rt=5, id_use_rt=0 -> no stall.
3. Redirect priority: ex_redirect=1 together with a load-use match -> if_id_flush=1, id_ex_bubble=1, pc_wr=1, flush_cnt=1, stall_cnt unchanged.
4. Mult/div with MD_CYCLES=4: ex_md_start held high ->
   - 3 freeze cycles: pc_wr=0, ex_mem_bubble=1, md_busy=1 on cycles 2-3.
   - 4th cycle: md_done=1 with all enables 1.
   - stall_cnt=3.
   - Back-to-back mult/div: a second 4-cycle sequence starts on the next cycle.
5. Reset mid-MDWAIT: rst pulse during the 2nd freeze cycle -> outputs 0 immediately; after release, md_busy=0 and a fresh ex_md_start restarts a full 4-cycle sequence.
6. Saturation with CNT_W=4: 20 consecutive load-use stalls -> stall_cnt stops at 15; 20 redirects -> flush_cnt stops at 15.
